// File: rtl/inst_rom_pkg.sv
// Shared definitions for the instruction ROM and its program loader.
//   INST_W     : instruction word width
//   ZERO_WORD  : all-zero instruction, returned on disabled/out-of-range fetch
//   ld_state_e : loader FSM state encoding
package inst_rom_pkg;

   localparam int unsigned INST_W = 32;

   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_DONE = 2'd2
   } ld_state_e;

endpackage

// File: rtl/rom_loader.sv
// Byte-stream program loader. It accepts big-endian bytes, assembles them into
// 32-bit words and drives a single write port into the instruction array. The
// CPU is held in reset while a load is in progress.
//   clk, rst       : clock, asynchronous active-high reset
//   load_start_i   : begin a load (only honoured in IDLE)
//   ld_valid_i/ld_byte_i/ld_last_i/ld_ready_o : byte stream handshake
//   cpu_hold_o     : CPU held in reset (LOAD and DONE)
//   load_done_o    : one-cycle pulse at end of load
//   ovf_o          : sticky, image larger than the array
//   ld_words_o     : words written by the last/current load (saturating)
//   we_o/waddr_o/wdata_o : write port into the array
module rom_loader
   import inst_rom_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_byte_i,
   input  logic              ld_last_i,
   output logic              ld_ready_o,
   output logic              cpu_hold_o,
   output logic              load_done_o,
   output logic              ovf_o,
   output logic [ADDR_W:0]   ld_words_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [INST_W-1:0] wdata_o
);

   localparam logic [ADDR_W:0] WPTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   ld_state_e         state_q, state_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [INST_W-1:0] asm_q, asm_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic              ovf_q, ovf_d;
   logic              hold_q;

   logic              accept;
   logic              wr_req;
   logic              full;
   logic [4:0]        shamt;
   logic [INST_W-1:0] word_full;

   assign accept = ld_valid_i && (state_q == LD_LOAD);
   assign wr_req = accept && ((bcnt_q == 2'd3) || ld_last_i);
   // wptr reaching 2^ADDR_W means the array is full; further writes are dropped.
   assign full   = wptr_q[ADDR_W];

   // Byte n lands at bits [31-8n -: 8]; 3-n equals ~n for a 2-bit count.
   assign shamt     = {~bcnt_q, 3'b000};
   assign word_full = asm_q | (INST_W'(ld_byte_i) << shamt);

   assign we_o    = wr_req && !full;
   assign waddr_o = wptr_q[ADDR_W-1:0];
   assign wdata_o = word_full;

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      asm_d   = asm_q;
      wptr_d  = wptr_q;
      ovf_d   = ovf_q;
      case (state_q)
         LD_IDLE: begin
            if (load_start_i) begin
               state_d = LD_LOAD;
               bcnt_d  = 2'd0;
               asm_d   = ZERO_WORD;
               wptr_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         LD_LOAD: begin
            if (accept) begin
               if (wr_req) begin
                  bcnt_d = 2'd0;
                  asm_d  = ZERO_WORD;
                  if (full) begin
                     ovf_d = 1'b1;
                  end else begin
                     wptr_d = wptr_q + WPTR_ONE;
                  end
                  if (ld_last_i) begin
                     state_d = LD_DONE;
                  end
               end else begin
                  asm_d  = word_full;
                  bcnt_d = bcnt_q + 2'd1;
               end
            end
         end
         LD_DONE: state_d = LD_IDLE;
         default: state_d = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LD_IDLE;
         bcnt_q  <= 2'd0;
         asm_q   <= ZERO_WORD;
         wptr_q  <= '0;
         ovf_q   <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         wptr_q  <= wptr_d;
         ovf_q   <= ovf_d;
         hold_q  <= (state_d != LD_IDLE);
      end
   end

   assign ld_ready_o  = (state_q == LD_LOAD);
   assign load_done_o = (state_q == LD_DONE);
   assign cpu_hold_o  = hold_q;
   assign ovf_o       = ovf_q;
   assign ld_words_o  = wptr_q;

endmodule

// File: rtl/inst_rom.sv
// Instruction memory on the CPU fetch interface, with an embedded program
// loader. Fetch is combinational and stays live during loading.
//   clk, rst     : clock, asynchronous active-high reset (array not reset)
//   ce_i, addr_i : fetch enable and byte address from the CPU
//   inst_o       : fetched instruction, zero when disabled or out of range
//   load_start_i, ld_valid_i, ld_byte_i, ld_last_i, ld_ready_o : loader stream
//   cpu_hold_o, load_done_o, ovf_o, ld_words_o : loader status
module inst_rom
   import inst_rom_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic [31:0]       addr_i,
   output logic [INST_W-1:0] inst_o,
   input  logic              load_start_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_byte_i,
   input  logic              ld_last_i,
   output logic              ld_ready_o,
   output logic              cpu_hold_o,
   output logic              load_done_o,
   output logic              ovf_o,
   output logic [ADDR_W:0]   ld_words_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [INST_W-1:0] mem [DEPTH];

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [INST_W-1:0] wdata;
   logic              in_range;
   logic              unused_byte_sel;

   rom_loader #(
      .ADDR_W (ADDR_W)
   ) u_loader (
      .clk          (clk),
      .rst          (rst),
      .load_start_i (load_start_i),
      .ld_valid_i   (ld_valid_i),
      .ld_byte_i    (ld_byte_i),
      .ld_last_i    (ld_last_i),
      .ld_ready_o   (ld_ready_o),
      .cpu_hold_o   (cpu_hold_o),
      .load_done_o  (load_done_o),
      .ovf_o        (ovf_o),
      .ld_words_o   (ld_words_o),
      .we_o         (we),
      .waddr_o      (waddr),
      .wdata_o      (wdata)
   );

   // Contents deliberately survive rst so a reset mid-load keeps finished words.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign in_range        = (addr_i[31:ADDR_W+2] == '0);
   assign unused_byte_sel = ^addr_i[1:0];

   always_comb begin
      inst_o = ZERO_WORD;
      if (ce_i && in_range) begin
         inst_o = mem[addr_i[ADDR_W+1:2]];
      end
   end

endmodule

// File: tb/tb_inst_rom.sv
module tb_inst_rom;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] addr;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_last;
   logic        start_m, start_s;

   logic [31:0] inst_m, inst_s;
   logic        ready_m, hold_m, done_m, ovf_m;
   logic [10:0] words_m;
   logic        ready_s, hold_s, done_s, ovf_s;
   logic [2:0]  words_s;

   int checks = 0;
   int errors = 0;
   int done_cnt_m = 0;
   int done_cnt_s = 0;
   int base;

   always #5 clk = ~clk;

   inst_rom #(.ADDR_W(10)) dut_m (
      .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst_m),
      .load_start_i(start_m), .ld_valid_i(ld_valid), .ld_byte_i(ld_byte),
      .ld_last_i(ld_last), .ld_ready_o(ready_m), .cpu_hold_o(hold_m),
      .load_done_o(done_m), .ovf_o(ovf_m), .ld_words_o(words_m)
   );

   inst_rom #(.ADDR_W(2)) dut_s (
      .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst_s),
      .load_start_i(start_s), .ld_valid_i(ld_valid), .ld_byte_i(ld_byte),
      .ld_last_i(ld_last), .ld_ready_o(ready_s), .cpu_hold_o(hold_s),
      .load_done_o(done_s), .ovf_o(ovf_s), .ld_words_o(words_s)
   );

   always @(negedge clk) begin
      if (done_m) done_cnt_m <= done_cnt_m + 1;
      if (done_s) done_cnt_s <= done_cnt_s + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns just after the next negedge.
   task automatic send(input logic [7:0] b, input logic last);
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fetch_m(input string tag, input logic [31:0] a, input logic [31:0] exp);
      ce   = 1'b1;
      addr = a;
      #1;
      chk(tag, inst_m, exp);
   endtask

   task automatic fetch_s(input string tag, input logic [31:0] a, input logic [31:0] exp);
      ce   = 1'b1;
      addr = a;
      #1;
      chk(tag, inst_s, exp);
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; addr = '0; ld_valid = 1'b0; ld_byte = '0;
      ld_last = 1'b0; start_m = 1'b0; start_s = 1'b0;
      #1;
      chk("rst_ready", 32'(ready_m), 32'd0);
      chk("rst_hold", 32'(hold_m), 32'd0);
      chk("rst_done", 32'(done_m), 32'd0);
      chk("rst_ovf", 32'(ovf_m), 32'd0);
      chk("rst_words", 32'(words_m), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Load 1: two full words
      base = done_cnt_m;
      start_m = 1'b1; @(negedge clk); start_m = 1'b0;
      #1;
      chk("l1_hold_entry", 32'(hold_m), 32'd1);
      chk("l1_ready", 32'(ready_m), 32'd1);
      send(8'h34, 0); send(8'h01, 0); send(8'h11, 0); send(8'h00, 0);
      #1 chk("l1_hold_mid", 32'(hold_m), 32'd1);
      send(8'h34, 0); send(8'h02, 0); send(8'h00, 0); send(8'h20, 1);
      #1;
      chk("l1_done_pulse", 32'(done_m), 32'd1);
      chk("l1_hold_done", 32'(hold_m), 32'd1);
      chk("l1_ready_done", 32'(ready_m), 32'd0);
      @(negedge clk); #1;
      chk("l1_hold_after", 32'(hold_m), 32'd0);
      chk("l1_done_after", 32'(done_m), 32'd0);
      chk("l1_done_count", 32'(done_cnt_m - base), 32'd1);
      chk("l1_words", 32'(words_m), 32'd2);
      fetch_m("f_addr0", 32'h0, 32'h34011100);
      fetch_m("f_addr4", 32'h4, 32'h34020020);
      fetch_m("f_addr6", 32'h6, 32'h34020020);
      fetch_m("f_oor", 32'h0000_1000, 32'h0);
      ce = 1'b0; addr = 32'h0; #1;
      chk("f_ce0", inst_m, 32'h0);
      @(negedge clk);

      // Load 2: partial final word zero-filled
      start_m = 1'b1; @(negedge clk); start_m = 1'b0;
      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
      send(8'h11, 0); send(8'h22, 1);
      idle(1); #1;
      chk("l2_words", 32'(words_m), 32'd2);
      fetch_m("l2_mem0", 32'h0, 32'hAABBCCDD);
      fetch_m("l2_mem1", 32'h4, 32'h11220000);
      ce = 1'b0;
      @(negedge clk);

      // Load 3: gaps and an ignored restart mid-load
      base = done_cnt_m;
      start_m = 1'b1; @(negedge clk); start_m = 1'b0;
      send(8'h34, 0); idle(2);
      send(8'h01, 0);
      start_m = 1'b1; @(negedge clk); start_m = 1'b0;
      send(8'h11, 0); send(8'h00, 0); idle(3);
      send(8'h34, 0); send(8'h02, 0); idle(1);
      send(8'h00, 0); send(8'h20, 1);
      idle(1); #1;
      chk("l3_words", 32'(words_m), 32'd2);
      chk("l3_done_count", 32'(done_cnt_m - base), 32'd1);
      chk("l3_hold_after", 32'(hold_m), 32'd0);
      fetch_m("l3_mem0", 32'h0, 32'h34011100);
      fetch_m("l3_mem1", 32'h4, 32'h34020020);
      ce = 1'b0;
      @(negedge clk);

      // Overflow on the 4-word instance: 5-word image, word i byte j = 0x10*i+j
      base = done_cnt_s;
      start_s = 1'b1; @(negedge clk); start_s = 1'b0;
      for (int k = 0; k < 19; k++) send(8'((k / 4) * 16 + (k % 4)), 0);
      #1;
      chk("ovf_no_early_done", 32'(done_cnt_s - base), 32'd0);
      chk("ovf_not_yet", 32'(ovf_s), 32'd0);
      chk("ovf_words_sat_pre", 32'(words_s), 32'd4);
      send(8'h43, 1);
      #1;
      chk("ovf_done_pulse", 32'(done_s), 32'd1);
      chk("ovf_flag", 32'(ovf_s), 32'd1);
      chk("ovf_words", 32'(words_s), 32'd4);
      fetch_s("ovf_mem0", 32'h0, 32'h00010203);
      fetch_s("ovf_mem3", 32'hC, 32'h30313233);
      fetch_s("ovf_oor", 32'h10, 32'h0);
      ce = 1'b0;
      @(negedge clk);

      // Reset mid-load after two bytes of word 1
      start_m = 1'b1; @(negedge clk); start_m = 1'b0;
      send(8'hCA, 0); send(8'hFE, 0); send(8'hF0, 0); send(8'h0D, 0);
      send(8'h99, 0); send(8'h88, 0);
      #1;
      chk("rst_mid_hold_pre", 32'(hold_m), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_hold", 32'(hold_m), 32'd0);
      chk("rst_mid_ready", 32'(ready_m), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      fetch_m("rst_mem0_kept", 32'h0, 32'hCAFEF00D);
      fetch_m("rst_mem1_kept", 32'h4, 32'h34020020);
      ce = 1'b0;
      @(negedge clk);

      // Fresh load; last on a word boundary writes exactly one word
      base = done_cnt_m;
      start_m = 1'b1; @(negedge clk); start_m = 1'b0;
      send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 1);
      idle(1); #1;
      chk("fresh_words", 32'(words_m), 32'd1);
      chk("fresh_done_count", 32'(done_cnt_m - base), 32'd1);
      chk("fresh_ovf", 32'(ovf_m), 32'd0);
      fetch_m("fresh_mem0", 32'h0, 32'h12345678);
      fetch_m("fresh_mem1", 32'h4, 32'h34020020);
      ce = 1'b0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
